// File: rtl/mem_image_packer_pkg.sv
// Shared types and constants for the testbench memory image packer.
package mem_image_packer_pkg;

    localparam int DEF_LINE_WORDS = 16;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam logic [31:0] INST_PAD_WORD = 32'h0000_0013;
    localparam logic [31:0] DATA_PAD_WORD = 32'h0000_0000;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } cacheline_type_t;

    typedef logic [DEF_LINE_WORDS*DEF_WORD_WIDTH-1:0] risc_v_cacheline_t;

    typedef enum logic [1:0] {
        MEM_PACK_FILL = 2'd0,
        MEM_PACK_PAD  = 2'd1,
        MEM_PACK_SEND = 2'd2
    } mem_packer_state_t;

endpackage

// File: rtl/mem_line_buffer.sv
// Word-indexed cacheline write buffer with index counter, line type and full/empty tracking.
module mem_line_buffer
    import mem_image_packer_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int IDX_WIDTH  = $clog2(LINE_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    input  cacheline_type_t                  wr_type,
    input  logic                             clear,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] line,
    output cacheline_type_t                  line_type,
    output logic [IDX_WIDTH-1:0]             index,
    output logic                             empty
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LINE_WORDS - 1);

    logic [LINE_WORDS*WORD_WIDTH-1:0] line_r;
    cacheline_type_t                  type_r;
    logic [IDX_WIDTH-1:0]             index_r;
    logic                             full_r;
    logic                             empty_s;

    assign empty_s   = !full_r && (index_r == '0);
    assign line      = line_r;
    assign line_type = type_r;
    assign index     = index_r;
    assign empty     = empty_s;

    // Write one word at the current index; the index parks at the last slot and full marks it taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_r  <= '0;
            type_r  <= INST;
            index_r <= '0;
            full_r  <= 1'b0;
        end else if (clear) begin
            index_r <= '0;
            full_r  <= 1'b0;
        end else if (wr_en) begin
            line_r[index_r*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
            if (empty_s) begin
                type_r <= wr_type;
            end
            if (index_r == LAST_IDX) begin
                full_r <= 1'b1;
            end else begin
                index_r <= index_r + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mem_image_packer.sv
// Packs a 32-bit word stream into padded cachelines and hands them to the memory loader.
// Defining MEM_PACKER_CHECKSUM_EN adds per-type wrapping checksums of transferred lines.
module mem_image_packer
    import mem_image_packer_pkg::*;
#(
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter int          WORD_WIDTH = DEF_WORD_WIDTH,
    parameter logic [31:0] INST_PAD   = INST_PAD_WORD,
    parameter logic [31:0] DATA_PAD   = DATA_PAD_WORD,
    parameter int          CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             word_valid,
    output logic                             word_ready,
    input  logic [WORD_WIDTH-1:0]            word_data,
    input  cacheline_type_t                  word_type,
    input  logic                             word_last,
    output logic                             load_valid,
    input  logic                             load_ready,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] cacheline,
    output cacheline_type_t                  cacheline_type,
    output logic [CNT_WIDTH-1:0]             inst_line_count,
    output logic [CNT_WIDTH-1:0]             data_line_count,
`ifdef MEM_PACKER_CHECKSUM_EN
    output logic [31:0]                      inst_checksum,
    output logic [31:0]                      data_checksum,
`endif
    output logic                             done
);

    localparam int                   IDX_WIDTH = $clog2(LINE_WORDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(LINE_WORDS - 1);

    mem_packer_state_t     state_r, state_s;
    logic                  ready_s, wr_en_s, clear_s, xfer_s, accept_s, mismatch_s;
    logic [WORD_WIDTH-1:0] wr_data_s, pad_s;
    logic [IDX_WIDTH-1:0]  index_s;
    logic                  empty_s;
    logic                  load_valid_r, done_r, last_r;
    logic [CNT_WIDTH-1:0]  inst_cnt_r, data_cnt_r;

    mem_line_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_s),
        .wr_data   (wr_data_s),
        .wr_type   (word_type),
        .clear     (clear_s),
        .line      (cacheline),
        .line_type (cacheline_type),
        .index     (index_s),
        .empty     (empty_s)
    );

    assign mismatch_s      = !empty_s && (word_type != cacheline_type);
    assign pad_s           = (cacheline_type == DATA) ? WORD_WIDTH'(DATA_PAD) : WORD_WIDTH'(INST_PAD);
    assign accept_s        = word_valid && ready_s;
    assign word_ready      = ready_s && reset;
    assign load_valid      = load_valid_r;
    assign inst_line_count = inst_cnt_r;
    assign data_line_count = data_cnt_r;
    assign done            = done_r;

    // Next-state and buffer control for fill / pad / send.
    always_comb begin
        state_s   = state_r;
        ready_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_data_s = word_data;
        clear_s   = 1'b0;
        xfer_s    = 1'b0;
        case (state_r)
            MEM_PACK_FILL: begin
                ready_s = !mismatch_s;
                if (word_valid && !mismatch_s) begin
                    wr_en_s = 1'b1;
                    if (index_s == LAST_IDX) begin
                        state_s = MEM_PACK_SEND;
                    end else if (word_last) begin
                        state_s = MEM_PACK_PAD;
                    end else begin
                        state_s = MEM_PACK_FILL;
                    end
                end else if (word_valid) begin
                    // The other-type word stays with the driver until this line is flushed.
                    state_s = MEM_PACK_PAD;
                end else begin
                    state_s = MEM_PACK_FILL;
                end
            end
            MEM_PACK_PAD: begin
                wr_en_s   = 1'b1;
                wr_data_s = pad_s;
                if (index_s == LAST_IDX) begin
                    state_s = MEM_PACK_SEND;
                end else begin
                    state_s = MEM_PACK_PAD;
                end
            end
            MEM_PACK_SEND: begin
                if (load_ready) begin
                    xfer_s  = 1'b1;
                    clear_s = 1'b1;
                    state_s = MEM_PACK_FILL;
                end else begin
                    state_s = MEM_PACK_SEND;
                end
            end
            default: begin
                state_s = MEM_PACK_FILL;
            end
        endcase
    end

    // State register; load_valid is registered so load_ready never reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= MEM_PACK_FILL;
            load_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            load_valid_r <= (state_s == MEM_PACK_SEND);
        end
    end

    // Line counters, sticky done, and whether the open line carries the image's last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_cnt_r <= '0;
            data_cnt_r <= '0;
            done_r     <= 1'b0;
            last_r     <= 1'b0;
        end else if (xfer_s) begin
            if (cacheline_type == INST) begin
                inst_cnt_r <= inst_cnt_r + CNT_WIDTH'(1);
            end else begin
                data_cnt_r <= data_cnt_r + CNT_WIDTH'(1);
            end
            if (last_r) begin
                done_r <= 1'b1;
            end
            last_r <= 1'b0;
        end else if (accept_s) begin
            done_r <= 1'b0;
            if (word_last) begin
                last_r <= 1'b1;
            end
        end
    end

`ifdef MEM_PACKER_CHECKSUM_EN
    logic [31:0] inst_sum_r, data_sum_r;

    function automatic logic [31:0] line_sum(input logic [LINE_WORDS*WORD_WIDTH-1:0] line);
        logic [31:0] acc;
        acc = 32'h0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            acc = acc + 32'(line[i*WORD_WIDTH +: WORD_WIDTH]);
        end
        return acc;
    endfunction

    assign inst_checksum = inst_sum_r;
    assign data_checksum = data_sum_r;

    // Accumulate every word of each transferred line, pads included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_sum_r <= 32'h0;
            data_sum_r <= 32'h0;
        end else if (xfer_s) begin
            if (cacheline_type == INST) begin
                inst_sum_r <= inst_sum_r + line_sum(cacheline);
            end else begin
                data_sum_r <= data_sum_r + line_sum(cacheline);
            end
        end
    end
`endif

endmodule
